// File: rtl/scalar_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and default parameters for the scalar data memory arbiter.
//   arb_state_t : arbiter FSM states
//   owner_t     : read-return owner tag
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int unsigned DATA_W           = 24;
    localparam int unsigned DEF_MAX_BURST    = 16;
    localparam int unsigned DEF_STARVE_LIMIT = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DMA  = 1'b1
    } owner_t;

endpackage

// File: rtl/scalar_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// scalar_mem_arbiter_if
// Bundles the three buses around the arbiter:
//   core_* : MEM-stage single accesses (req/we/addr/wdata in, stall/rdata/rvalid out)
//   dma_*  : burst loader (req/we/addr/len/wdata/wvalid in,
//            gnt/beat/rdata/rvalid/done out)
//   mem_*  : scalar data port of the memory (addr/wdata/write/read out, rdata in)
// Modports:
//   slave  : arbiter view
//   master : view of the clients and the memory (testbench side)
// -----------------------------------------------------------------------------
interface scalar_mem_arbiter_if #(
    parameter int N     = 24,
    parameter int LEN_W = 4
);

    // core side
    logic             core_req;
    logic             core_we;
    logic [N-1:0]     core_addr;
    logic [N-1:0]     core_wdata;
    logic             core_stall;
    logic [N-1:0]     core_rdata;
    logic             core_rvalid;

    // loader side
    logic             dma_req;
    logic             dma_we;
    logic [N-1:0]     dma_addr;
    logic [LEN_W-1:0] dma_len;
    logic [N-1:0]     dma_wdata;
    logic             dma_wvalid;
    logic             dma_gnt;
    logic             dma_beat;
    logic [N-1:0]     dma_rdata;
    logic             dma_rvalid;
    logic             dma_done;

    // memory side
    logic [N-1:0]     mem_addr;
    logic [N-1:0]     mem_wdata;
    logic             mem_write;
    logic             mem_read;
    logic [N-1:0]     mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_stall, core_rdata, core_rvalid,
        input  dma_req, dma_we, dma_addr, dma_len, dma_wdata, dma_wvalid,
        output dma_gnt, dma_beat, dma_rdata, dma_rvalid, dma_done,
        output mem_addr, mem_wdata, mem_write, mem_read,
        input  mem_rdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_stall, core_rdata, core_rvalid,
        output dma_req, dma_we, dma_addr, dma_len, dma_wdata, dma_wvalid,
        input  dma_gnt, dma_beat, dma_rdata, dma_rvalid, dma_done,
        input  mem_addr, mem_wdata, mem_write, mem_read,
        output mem_rdata
    );

endinterface

// File: rtl/scalar_mem_arbiter_burst_addr_gen.sv
// -----------------------------------------------------------------------------
// burst_addr_gen
// Sequential address generator for loader bursts.
//   clk, rst   : clock, synchronous active-high reset
//   load_i     : capture base_i/len_i and restart at beat 0
//   advance_i  : a beat was issued this cycle
//   base_i     : burst base address
//   len_i      : burst length minus one
//   addr_o     : current beat address, base + beat count (wraps mod 2^N)
//   last_o     : current beat is the final one
// -----------------------------------------------------------------------------
module burst_addr_gen
    import mem_arb_pkg::*;
#(
    parameter int N     = DATA_W,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             advance_i,
    input  logic [N-1:0]     base_i,
    input  logic [LEN_W-1:0] len_i,
    output logic [N-1:0]     addr_o,
    output logic             last_o
);

    logic [N-1:0]     base_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (advance_i) begin
            // Return to zero after the last beat so an idle generator is clean.
            cnt_d = last_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
        end else begin
            if (load_i) begin
                base_q <= base_i;
                len_q  <= len_i;
            end
            cnt_q <= cnt_d;
        end
    end

    assign addr_o = base_q + N'(cnt_q);
    assign last_o = (cnt_q == len_q);

endmodule

// File: rtl/scalar_mem_arbiter.sv
// -----------------------------------------------------------------------------
// scalar_mem_arbiter
// Shares the scalar data memory port between the core MEM stage (priority,
// single-cycle) and a burst loader (non-preemptible bursts, starvation guard).
//   clk, rst : clock, synchronous active-high reset
//   bus      : scalar_mem_arbiter_if.slave carrying the core_*, dma_* and
//              mem_* signals
//
// state | meaning
// IDLE  | core served combinationally; loader granted when core is quiet or
//       | the starvation counter has reached its limit
// BURST | loader beats issued back to back (write beats wait for dma_wvalid)
// -----------------------------------------------------------------------------
module scalar_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N            = DATA_W,
    parameter int MAX_BURST    = DEF_MAX_BURST,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                 clk,
    input  logic                 rst,
    scalar_mem_arbiter_if.slave  bus
);

    localparam int LEN_W = $clog2(MAX_BURST);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);

    arb_state_t       state_q, state_d;
    logic [STV_W-1:0] starve_q, starve_d;
    logic             we_q;
    logic             rd_pend_q;
    owner_t           tag_q;
    logic [N-1:0]     addr_hold_q;
    logic [N-1:0]     wdata_hold_q;

    logic             grant;
    logic             core_go;
    logic             beat;
    logic             done;
    logic [N-1:0]     gen_addr;
    logic             gen_last;
    logic [N-1:0]     mem_addr_c;
    logic [N-1:0]     mem_wdata_c;
    logic             mem_read_c;
    logic             mem_write_c;

    burst_addr_gen #(
        .N     (N),
        .LEN_W (LEN_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load_i    (grant),
        .advance_i (beat),
        .base_i    (bus.dma_addr),
        .len_i     (bus.dma_len),
        .addr_o    (gen_addr),
        .last_o    (gen_last)
    );

    // Decisions are gated by rst so the reset cycle itself shows reset values.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        grant    = 1'b0;
        core_go  = 1'b0;
        beat     = 1'b0;
        done     = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (bus.dma_req && (!bus.core_req || starve_q == STV_MAX)) begin
                        grant    = 1'b1;
                        starve_d = '0;
                        state_d  = BURST;
                    end else if (bus.core_req) begin
                        core_go = 1'b1;
                        if (bus.dma_req && starve_q != STV_MAX) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end
                end
                BURST: begin
                    beat = !we_q || bus.dma_wvalid;
                    if (beat && gen_last) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        mem_write_c = (core_go && bus.core_we) || (beat && we_q);
        mem_read_c  = (core_go && !bus.core_we) || (beat && !we_q);
        // Address/data hold their last driven value when the port is idle.
        if (rst) begin
            mem_addr_c  = '0;
            mem_wdata_c = '0;
        end else if (core_go) begin
            mem_addr_c  = bus.core_addr;
            mem_wdata_c = bus.core_wdata;
        end else if (beat) begin
            mem_addr_c  = gen_addr;
            mem_wdata_c = we_q ? bus.dma_wdata : wdata_hold_q;
        end else begin
            mem_addr_c  = addr_hold_q;
            mem_wdata_c = wdata_hold_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_q     <= '0;
            we_q         <= 1'b0;
            rd_pend_q    <= 1'b0;
            tag_q        <= OWN_CORE;
            addr_hold_q  <= '0;
            wdata_hold_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            rd_pend_q    <= mem_read_c;
            addr_hold_q  <= mem_addr_c;
            wdata_hold_q <= mem_wdata_c;
            if (grant) begin
                we_q <= bus.dma_we;
            end
            if (mem_read_c) begin
                tag_q <= core_go ? OWN_CORE : OWN_DMA;
            end
        end
    end

    assign bus.mem_addr    = mem_addr_c;
    assign bus.mem_wdata   = mem_wdata_c;
    assign bus.mem_write   = mem_write_c;
    assign bus.mem_read    = mem_read_c;

    assign bus.core_stall  = !rst && bus.core_req && !core_go;
    assign bus.dma_gnt     = grant;
    assign bus.dma_beat    = beat;
    assign bus.dma_done    = done;

    // Memory returns data the cycle after the read; the tag picks the owner.
    assign bus.core_rvalid = !rst && rd_pend_q && (tag_q == OWN_CORE);
    assign bus.dma_rvalid  = !rst && rd_pend_q && (tag_q == OWN_DMA);
    assign bus.core_rdata  = bus.core_rvalid ? bus.mem_rdata : '0;
    assign bus.dma_rdata   = bus.dma_rvalid ? bus.mem_rdata : '0;

endmodule
